cordic_post_stage: RTL and testbench
====================================

# cordic_post_stage

Output stage of the 16-stage CORDIC rotation pipeline, directly downstream of the final shift-accumulate stage (iteration 15). Each cycle it takes the final x/y/z triple plus the 2-bit quadrant tag that travelled alongside the pipeline, and undoes the input quadrant fold to produce signed cos/sin results. Results are buffered in a small FIFO with a valid/ready handshake, because the rotation pipeline itself cannot stall. Data format is signed Q2.30 throughout, so 1.0 = 0x4000_0000.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  x_in/y_in/z_in/quad_in are valid this cycle.
- x_in  in  32  final x from stage 15; Q2.30, gain-compensated.
- y_in  in  32  final y from stage 15; Q2.30.
- z_in  in  32  residual angle from stage 15.
- quad_in  in  2  quadrant tag carried through the pipeline.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the head this cycle.
- cos_out  out  32  corrected cosine at the FIFO head.
- sin_out  out  32  corrected sine at the FIFO head.
- resid_out  out  32  z residual at the FIFO head, passed through unchanged.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky: a valid input was dropped.

## Operation
- Correction register S1 is loaded when in_valid=1. S1 holds the corrected cos/sin, z_in, and a valid bit.
- Quadrant map:
  - 0: cos=x, sin=y
  - 1: cos=-y, sin=x
  - 2: cos=-x, sin=-y
  - 3: cos=y, sin=-x
- Negation is 32-bit two's complement.
- When S1 is valid, its contents are pushed into the FIFO on the next edge.
- Push is accepted when level<DEPTH, or when level==DEPTH and a pop happens in the same cycle.
- A rejected push discards the entry and sets overflow. Overflow clears only on reset.
- A pop happens when out_valid && out_ready.
- The head outputs are the memory entry addressed by the read pointer (first-word fall-through).
- Pointers are log2(DEPTH) bits and wrap naturally.
- Simultaneous push and pop leave level unchanged.
- A pop while empty is ignored.
- out_valid = (level != 0).

## Timing
- Reset (asynchronous, rst_n=0) clears:
  - S1 valid
  - both pointers
  - level = 0
  - overflow = 0
  - out_valid = 0
  - cos_out, sin_out and resid_out read 0. FIFO memory is cleared on reset.
- Latency: in_valid sampled at edge N → S1 valid after N → FIFO written at N+1 → out_valid high after N+1. Two cycles from input to output.
- Throughput: one result per cycle sustained, while out_ready is held high.
- out_valid and head data stay stable while out_ready=0.
- Asserting rst_n low mid-stream discards all entries immediately. The first output after release needs a fresh in_valid.
- overflow rises in the cycle after the rejected push edge.

## Configuration
- CORDIC_SAT_EN defined:
  - cos and sin are clamped to [0xC000_0000, 0x4000_0000] after correction.
  - Negating 0x8000_0000 yields 0x4000_0000.
  - Clamping adds no cycles.
- CORDIC_SAT_EN undefined:
  - No clamping; plain two's-complement wrap.
  - -0x8000_0000 = 0x8000_0000.

## Test plan
- Reset, then in_valid with x=0x2D41_3CCD, y=0x2D41_3CCD, quad=2 → two cycles later out_valid=1, cos=sin=0xD2BE_C333, resid=z_in.
- Four consecutive inputs with quad=0,1,2,3, x=0x4000_0000, y=0, out_ready=1 → (cos,sin) = (0x4000_0000,0), (0,0x4000_0000), (0xC000_0000,0), (0,0xC000_0000) in order, one per cycle.
- out_ready=0, six back-to-back inputs → level=4; overflow=1 after the 5th push edge. Then draining with out_ready=1 yields inputs 1–4 unchanged.
- level=4 with simultaneous push and pop → level stays 4, overflow stays 0, order preserved.
- x=0x8000_0000, quad=2 → cos=0x4000_0000 with CORDIC_SAT_EN; cos=0x8000_0000 without it.
- rst_n pulsed low with 3 entries queued → out_valid=0 and level=0 immediately. Entries do not reappear after rst_n returns high.

Source files
------------

// File: rtl/cordic_post_stage.sv
// cordic_post_stage: undoes the quadrant fold of the final CORDIC triple and queues results.
// Define CORDIC_SAT_EN to clamp cos/sin to [-1.0, +1.0] in Q2.30.
module cordic_post_stage #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [31:0]              x_in,
    input  logic [31:0]              y_in,
    input  logic [31:0]              z_in,
    input  logic [1:0]               quad_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              cos_out,
    output logic [31:0]              sin_out,
    output logic [31:0]              resid_out,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

`ifdef CORDIC_SAT_EN
    // One guard bit so that negating 0x8000_0000 becomes +2.0 before clamping.
    localparam int CW = 33;
`else
    localparam int CW = 32;
`endif

    typedef logic signed [CW-1:0] wide_t;

    typedef struct packed {
        logic [31:0] cos;
        logic [31:0] sin;
        logic [31:0] resid;
    } entry_t;

`ifdef CORDIC_SAT_EN
    localparam wide_t POS_ONE = wide_t'(32'sh4000_0000);
    localparam wide_t NEG_ONE = -POS_ONE;
`endif

    function automatic logic [31:0] fit(input wide_t v);
`ifdef CORDIC_SAT_EN
        if (v > POS_ONE) begin
            return 32'h4000_0000;
        end
        if (v < NEG_ONE) begin
            return 32'hC000_0000;
        end
`endif
        return v[31:0];
    endfunction

    wide_t  wx;
    wide_t  wy;
    wide_t  nx;
    wide_t  ny;
    wide_t  c_cos;
    wide_t  c_sin;

    assign wx = wide_t'(signed'(x_in));
    assign wy = wide_t'(signed'(y_in));
    assign nx = -wx;
    assign ny = -wy;

    always_comb begin
        c_cos = wx;
        c_sin = wy;
        unique case (quad_in)
            2'd0: begin
                c_cos = wx;
                c_sin = wy;
            end
            2'd1: begin
                c_cos = ny;
                c_sin = wx;
            end
            2'd2: begin
                c_cos = nx;
                c_sin = ny;
            end
            2'd3: begin
                c_cos = wy;
                c_sin = nx;
            end
        endcase
    end

    logic    s1_valid;
    entry_t  s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1.cos   <= fit(c_cos);
                s1.sin   <= fit(c_sin);
                s1.resid <= z_in;
            end
        end
    end

    entry_t         mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           push;
    logic           pop;
    logic           full;
    logic           accept;
    entry_t         head;

    assign full   = (level == LW'(DEPTH));
    assign pop    = out_valid && out_ready;
    assign push   = s1_valid;
    // A full FIFO still takes the push when the head leaves on the same edge.
    assign accept = push && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (accept) begin
                mem[wr_ptr] <= s1;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !accept) begin
                overflow <= 1'b1;
            end
            unique case ({accept, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    assign head      = mem[rd_ptr];
    assign out_valid = (level != '0);
    assign cos_out   = head.cos;
    assign sin_out   = head.sin;
    assign resid_out = head.resid;

endmodule

// File: tb/tb_cordic_post_stage.sv
// Bench for cordic_post_stage: vector table through a scoreboard plus FIFO corner sequences.
// Build with +define+CORDIC_SAT_EN to check the clamping variant.
module tb_cordic_post_stage;

`ifdef CORDIC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] x_in;
    logic [31:0] y_in;
    logic [31:0] z_in;
    logic [1:0]  quad_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] cos_out;
    logic [31:0] sin_out;
    logic [31:0] resid_out;
    logic [2:0]  level;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] c;
        logic [31:0] s;
        logic [31:0] r;
    } exp_t;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic [1:0]  q;
        logic [31:0] c;
        logic [31:0] s;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[9];

    cordic_post_stage #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .x_in      (x_in),
        .y_in      (y_in),
        .z_in      (z_in),
        .quad_in   (quad_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cos_out   (cos_out),
        .sin_out   (sin_out),
        .resid_out (resid_out),
        .level     (level),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Consumer side: compare every popped head against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got cos %h, expected no output",
                         cos_out);
            end else begin
                mon_e = sb.pop_front();
                check("head_cos", cos_out, mon_e.c);
                check("head_sin", sin_out, mon_e.s);
                check("head_resid", resid_out, mon_e.r);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input vec_t v, input bit keep);
        x_in     = v.x;
        y_in     = v.y;
        z_in     = v.z;
        quad_in  = v.q;
        in_valid = 1'b1;
        if (keep) begin
            sb.push_back('{v.c, v.s, v.z});
        end
        step();
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid) && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (sb.size() != 0 || out_valid) begin
            errors++;
            $display("FAIL %s_drain: got %0d pending, expected 0", name, sb.size());
        end
        check({name, "_level_empty"}, {29'b0, level}, 32'd0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        sb.delete();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'h2D41_3CCD, 32'h2D41_3CCD, 32'h0000_1234, 2'd2,
                    32'hD2BE_C333, 32'hD2BE_C333};
        vecs[1] = '{32'h4000_0000, 32'h0, 32'h0000_0001, 2'd0,
                    32'h4000_0000, 32'h0};
        vecs[2] = '{32'h4000_0000, 32'h0, 32'h0000_0002, 2'd1,
                    32'h0, 32'h4000_0000};
        vecs[3] = '{32'h4000_0000, 32'h0, 32'h0000_0003, 2'd2,
                    32'hC000_0000, 32'h0};
        vecs[4] = '{32'h4000_0000, 32'h0, 32'h0000_0004, 2'd3,
                    32'h0, 32'hC000_0000};
        vecs[5] = '{32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 2'd2,
                    SAT ? 32'h4000_0000 : 32'h8000_0000, 32'h0};
        vecs[6] = '{32'h1234_5678, 32'h0F0F_0F0F, 32'hA5A5_0006, 2'd1,
                    32'hF0F0_F0F1, 32'h1234_5678};
        vecs[7] = '{32'h0000_0001, 32'h7FFF_FFFF, 32'h0000_0007, 2'd3,
                    SAT ? 32'h4000_0000 : 32'h7FFF_FFFF, 32'hFFFF_FFFF};
        vecs[8] = '{32'h9000_0000, 32'h3FFF_FFFF, 32'h8000_0008, 2'd0,
                    SAT ? 32'hC000_0000 : 32'h9000_0000, 32'h3FFF_FFFF};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x_in      = '0;
        y_in      = '0;
        z_in      = '0;
        quad_in   = '0;
        repeat (2) step();
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_level", {29'b0, level}, 32'd0);
        check("rst_overflow", {31'b0, overflow}, 32'd0);
        check("rst_cos", cos_out, 32'd0);
        check("rst_sin", sin_out, 32'd0);
        check("rst_resid", resid_out, 32'd0);
        rst_n = 1'b1;
        step();

        // Two-cycle latency, then head contents via the scoreboard.
        send(vecs[0], 1'b1);
        in_valid = 1'b0;
        check("lat_after_1", {31'b0, out_valid}, 32'd0);
        step();
        check("lat_after_2", {31'b0, out_valid}, 32'd1);
        check("lat_level", {29'b0, level}, 32'd1);
        drain("latency");

        // Table, back-to-back with the consumer always ready.
        out_ready = 1'b1;
        for (int i = 1; i < 9; i++) begin
            send(vecs[i], 1'b1);
        end
        in_valid = 1'b0;
        step();
        step();
        check("stream_done_pending", sb.size(), 32'd0);
        drain("table");

        // Six inputs into a stalled FIFO: 5th and 6th are dropped.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send(vecs[i + 1], i < 4);
            if (i == 4) begin
                check("ovf_level_full", {29'b0, level}, 32'd4);
                check("ovf_not_yet", {31'b0, overflow}, 32'd0);
            end
        end
        in_valid = 1'b0;
        check("ovf_set", {31'b0, overflow}, 32'd1);
        step();
        check("ovf_level_held", {29'b0, level}, 32'd4);
        check("hold_cos", cos_out, sb[0].c);
        step();
        check("hold_cos_2", cos_out, sb[0].c);
        check("hold_valid", {31'b0, out_valid}, 32'd1);
        drain("overflow");
        check("ovf_sticky", {31'b0, overflow}, 32'd1);

        pulse_reset();
        check("ovf_cleared", {31'b0, overflow}, 32'd0);

        // Full FIFO with a push and pop on the same edge.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(vecs[i + 5 - (i / 4) * 9], 1'b1);
        end
        send(vecs[0], 1'b1);
        check("pp_full", {29'b0, level}, 32'd4);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("pp_level", {29'b0, level}, 32'd4);
        check("pp_overflow", {31'b0, overflow}, 32'd0);
        drain("pushpop");

        // Reset with three entries queued.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(vecs[i + 2], 1'b1);
        end
        in_valid = 1'b0;
        step();
        check("mid_level_3", {29'b0, level}, 32'd3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_level", {29'b0, level}, 32'd0);
        check("mid_rst_cos", cos_out, 32'd0);
        sb.delete();
        #1;
        rst_n = 1'b1;
        repeat (3) step();
        check("post_rst_valid", {31'b0, out_valid}, 32'd0);
        check("post_rst_level", {29'b0, level}, 32'd0);
        send(vecs[6], 1'b1);
        drain("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
